// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad emulator:
//   keyState_t     - emulator state machine encoding (IDLE / PRESS / RELEASE)
//   CNT_W          - width of the press / release cycle counters
//   CNT_MAX_INT    - largest value the counters can hold (they saturate there)
//   BOUNCE_WINDOW  - number of leading PRESS cycles subject to contact bounce
//   IDLE_ROW       - row value presented when no key is pressed
//   KEY_POS_TABLE  - key code -> {row index, column index} lookup
//   keyPos()       - helper that reads KEY_POS_TABLE
// ---------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } keyState_t;

  localparam int          CNT_W         = 24;
  localparam int unsigned CNT_MAX_INT   = (32'd1 << CNT_W) - 32'd1;
  localparam int          BOUNCE_WINDOW = 32;
  localparam logic [3:0]  IDLE_ROW      = 4'hF;

  // Entry k holds {row[1:0], col[1:0]} for key code k.
  // Layout (rows top to bottom, columns c0..c3 left to right):
  //   r0: 1 2 3 A
  //   r1: 4 5 6 B
  //   r2: 7 8 9 C
  //   r3: 0 F E D
  // Packed so that entry 15 (key F) is the leftmost nibble.
  localparam logic [15:0][3:0] KEY_POS_TABLE = 64'hDEFB_73A9_8654_210C;

  // Returns {row index, column index} for a key code.
  function automatic logic [3:0] keyPos(input logic [3:0] key);
    return KEY_POS_TABLE[key];
  endfunction

endpackage

// File: rtl/keypad_keymap.sv
// ---------------------------------------------------------------------------
// keypad_keymap
// Purely combinational key-position lookup.
// Ports:
//   i_keyCode [3:0] - key code 0x0..0xF
//   o_rowIdx  [1:0] - row index r of that key
//   o_colIdx  [1:0] - column index c of that key
// ---------------------------------------------------------------------------
module keypad_keymap
  import keypad_pkg::*;
(
  input  logic [3:0] i_keyCode,
  output logic [1:0] o_rowIdx,
  output logic [1:0] o_colIdx
);

  logic [3:0] w_pos;

  // Split the table entry into its row and column halves.
  always_comb begin
    w_pos    = keyPos(i_keyCode);
    o_rowIdx = w_pos[3:2];
    o_colIdx = w_pos[1:0];
  end

endmodule

// File: rtl/keypad_emulator.sv
// ---------------------------------------------------------------------------
// keypad_emulator
// Emulates a 4x4 matrix keypad being pressed by a finger. A key request is
// accepted in IDLE, the key is held for PRESS_CYCLES clocks (min 1), then all
// keys are released for RELEASE_CYCLES clocks (min 1) before the next request.
// While pressed, the key's row line follows its column strobe with one clock
// of latency, the way a real switch would connect the two lines.
//
// Optional feature: define KEYPAD_EMU_BOUNCE_EN to add contact bounce during
// the first BOUNCE_WINDOW press cycles (the key reads released in every cycle
// whose press count has bit 2 set). Without the macro the press is clean.
//
// Ports:
//   clk             - clock, all state changes on rising edge
//   clr             - synchronous active-high reset
//   key_valid       - key request present on key_code
//   key_code  [3:0] - key to press (0x0..0xF)
//   key_ready       - high in IDLE; request accepted when valid & ready
//   col       [3:0] - active-low column strobes from the scanner
//   row       [3:0] - active-low row returns to the scanner (registered)
//   busy            - high while in PRESS or RELEASE
//   press_done      - one-cycle pulse in the first RELEASE cycle
// ---------------------------------------------------------------------------
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int PRESS_CYCLES   = 2000,
  parameter int RELEASE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       press_done
);

  // Zero or negative lengths still give a one-cycle phase; lengths beyond
  // the counter range are clipped to the saturation value.
  localparam int unsigned PRESS_LEN   = (PRESS_CYCLES   < 1) ? 1 : PRESS_CYCLES;
  localparam int unsigned RELEASE_LEN = (RELEASE_CYCLES < 1) ? 1 : RELEASE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(CNT_MAX_INT);
  localparam logic [CNT_W-1:0] PRESS_LAST   = ((PRESS_LEN - 1) > CNT_MAX_INT)
                                              ? CNT_MAX : CNT_W'(PRESS_LEN - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = ((RELEASE_LEN - 1) > CNT_MAX_INT)
                                              ? CNT_MAX : CNT_W'(RELEASE_LEN - 1);

  keyState_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_rowIdx;
  logic [1:0]       r_colIdx;
  logic [1:0]       w_keyRow;
  logic [1:0]       w_keyCol;
  logic [CNT_W-1:0] w_cntInc;

  keypad_keymap u_keymap (
    .i_keyCode (key_code),
    .o_rowIdx  (w_keyRow),
    .o_colIdx  (w_keyCol)
  );

  // Counter increment that sticks at the maximum instead of wrapping.
  assign w_cntInc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Row value for a pressed key: both lines are active low, so the pressed
  // row simply copies its column bit. Only the latched column bit matters,
  // which keeps non-one-hot strobes working.
  function automatic logic [3:0] pressRow(input logic [1:0] rIdx,
                                          input logic [1:0] cIdx,
                                          input logic [3:0] colIn);
    logic [3:0] v;
    v       = IDLE_ROW;
    v[rIdx] = colIn[cIdx];
    return v;
  endfunction

`ifdef KEYPAD_EMU_BOUNCE_EN
  // True for press counts in the bounce window whose bit 2 is set, giving
  // 4 cycles closed / 4 cycles open until the window ends.
  function automatic logic bounceOpen(input logic [CNT_W-1:0] cnt);
    return (cnt < CNT_W'(BOUNCE_WINDOW)) && cnt[2];
  endfunction
`endif

  // Main state machine. The counter holds the index of the current cycle
  // within PRESS or RELEASE, so a phase ends when it reaches its last index.
  // Row is computed from the state and count that the edge is moving into,
  // which keeps it low exactly during PRESS cycles and 4'hF otherwise.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rowIdx   <= '0;
      r_colIdx   <= '0;
      row        <= IDLE_ROW;
      key_ready  <= 1'b1;
      busy       <= 1'b0;
      press_done <= 1'b0;
    end else begin
      press_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (key_valid) begin
            r_state   <= ST_PRESS;
            r_cnt     <= '0;
            r_rowIdx  <= w_keyRow;
            r_colIdx  <= w_keyCol;
            row       <= pressRow(w_keyRow, w_keyCol, col);
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            row <= IDLE_ROW;
          end
        end

        ST_PRESS: begin
          if (r_cnt == PRESS_LAST) begin
            r_state    <= ST_RELEASE;
            r_cnt      <= '0;
            row        <= IDLE_ROW;
            press_done <= 1'b1;
          end else begin
            r_cnt <= w_cntInc;
`ifdef KEYPAD_EMU_BOUNCE_EN
            if (bounceOpen(w_cntInc)) begin
              row <= IDLE_ROW;
            end else begin
              row <= pressRow(r_rowIdx, r_colIdx, col);
            end
`else
            row <= pressRow(r_rowIdx, r_colIdx, col);
`endif
          end
        end

        ST_RELEASE: begin
          row <= IDLE_ROW;
          if (r_cnt == RELEASE_LAST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r_cnt <= w_cntInc;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          row       <= IDLE_ROW;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 SHALL have parameter PRESS_CYCLES, default 2000: number of clk cycles a key is held pressed.
REQ-002 SHALL have parameter RELEASE_CYCLES, default 1000: number of clk cycles all keys are released after a press, before the next key is accepted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port key_valid, input, 1 bit: a key request is present on key_code.
REQ-006 SHALL have port key_code, input, 4 bits: value 0x0-0xF of the key to press.
REQ-007 SHALL have port key_ready, output, 1 bit: the emulator can accept a key request.
REQ-008 SHALL have port col, input, 4 bits: active-low column strobes, driven by the keypad scanner.
REQ-009 SHALL have port row, output, 4 bits: active-low row returns, read by the scanner.
REQ-010 SHALL have port busy, output, 1 bit: high while in PRESS or RELEASE.
REQ-011 SHALL have port press_done, output, 1 bit: one-cycle pulse when PRESS ends.

Function
REQ-012 SHALL map keys to positions as follows, with row index r and column bit c:
- r0 = 1,2,3,A
- r1 = 4,5,6,B
- r2 = 7,8,9,C
- r3 = 0,F,E,D
- column order is c0..c3, left to right.
REQ-013 SHALL implement a state machine with states IDLE, PRESS and RELEASE.
REQ-014 SHALL drive key_ready high only in IDLE; a request is accepted on the edge where key_valid and key_ready are both high.
REQ-015 SHALL, on acceptance, latch the position of key_code and enter PRESS; key_code changes after acceptance have no effect.
REQ-016 SHALL stay in PRESS for exactly max(PRESS_CYCLES,1) cycles, then enter RELEASE and pulse press_done in the first RELEASE cycle.
REQ-017 SHALL stay in RELEASE for exactly max(RELEASE_CYCLES,1) cycles, then return to IDLE.
REQ-018 SHALL register row, with one cycle of latency from col: row[r] = 0 iff the state is PRESS, r is the latched row, and col[c] = 0 for the latched column c; otherwise row[r] = 1.
REQ-019 SHALL evaluate the latched column bit independently of the other col bits, so a non-one-hot col still presses the key when its column bit is low.
REQ-020 SHALL drive row = 4'hF in IDLE and RELEASE.
REQ-021 SHALL ignore key_valid while busy; requests are not queued.
REQ-022 SHALL use cycle counters at least 24 bits wide and saturate them, never wrapping.

Reset
REQ-023 SHALL, while clr = 1, force on the next edge: state IDLE, row = 4'hF, key_ready = 1, busy = 0, press_done = 0, counters = 0.
REQ-024 SHALL, when clr is asserted mid-PRESS, release the key on the next edge with no press_done pulse.
REQ-025 SHALL give clr priority over a simultaneous handshake; the request is dropped.

Configuration
REQ-026 SHALL, when macro KEYPAD_EMU_BOUNCE_EN is defined, inject contact bounce: during the first 32 PRESS cycles, a key in a cycle whose press count has bit 2 set reads as released (row = 4'hF).
REQ-027 SHALL, when KEYPAD_EMU_BOUNCE_EN is undefined, present a clean press for the whole PRESS duration.

Structure
REQ-028 SHALL take from the shared package keypad_pkg:
- the state enum;
- the key-to-(row,column) table;
- the constants BOUNCE_WINDOW = 32 and IDLE_ROW = 4'hF.
REQ-029 SHALL place the key-position lookup in one sub-module, keypad_keymap, which is combinational: key_code in, row index and column index out.

Verification
REQ-030 SHALL pass this scenario: PRESS_CYCLES = 8, RELEASE_CYCLES = 4, key 5 accepted, col = 4'b1101 held. Required response: row = 4'b1101 on 8 consecutive cycles starting one cycle after acceptance, then 4'hF; press_done pulses once; key_ready returns 4 cycles later.
REQ-031 SHALL pass this scenario: key D (r3, c3) pressed while a scanner rotates col through 1110, 1101, 1011, 0111. Required response: row = 4'b0111 only in the cycle after col = 4'b0111; 4'hF otherwise.
REQ-032 SHALL pass this scenario: key_valid held with key_code = 2 while busy. Required response: no acceptance until IDLE, then exactly one new press.
REQ-033 SHALL pass this scenario: clr asserted at the 3rd PRESS cycle. Required response: next edge gives row = 4'hF, key_ready = 1, press_done = 0.
REQ-034 SHALL pass this scenario: PRESS_CYCLES = 0 and RELEASE_CYCLES = 0. Required response: a 1-cycle press and a 1-cycle release.
REQ-035 SHALL pass this scenario, with KEYPAD_EMU_BOUNCE_EN defined, key 1 pressed and col = 4'b1110. Required response: row alternates 4 cycles 4'b1110 and 4 cycles 4'hF for 32 cycles, then holds 4'b1110.
